// File: rtl/vga_pixel_feeder.sv
// Purpose: turns VGA controller pixel requests into frame-buffer FIFO reads and expands RGB565/mono8 words to 10-bit R/G/B.
// Latency: fixed 2 cycles from iRequest to pixel on oRed/oGreen/oBlue; one pixel per cycle with no bubbles.
// Backpressure: none; a request that finds the FIFO empty is not stalled but emits one fill pixel and is counted.
module vga_pixel_feeder #(
    parameter logic [9:0] FILL_R = 10'h3FF,
    parameter logic [9:0] FILL_G = 10'h000,
    parameter logic [9:0] FILL_B = 10'h000,
    parameter int         CNT_W  = 16
) (
    input  logic             iCLK,
    input  logic             iRST_N,
    input  logic             iRequest,
    input  logic             iVGA_V_SYNC,
    input  logic             iMODE,
    input  logic [15:0]      iFIFO_DATA,
    input  logic             iFIFO_EMPTY,
    output logic             oFIFO_RD,
    output logic [9:0]       oRed,
    output logic [9:0]       oGreen,
    output logic [9:0]       oBlue,
    output logic             oUnderflow,
    output logic [CNT_W-1:0] oUnderflow_Cnt
);

    logic             req_d;
    logic             uf_d;
    logic             vs_d;
    logic             mode_q;
    logic             sticky_uf;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] last_cnt;
    logic [CNT_W-1:0] run_next;
    logic [9:0]       red_q;
    logic [9:0]       green_q;
    logic [9:0]       blue_q;
    logic [9:0]       exp_r;
    logic [9:0]       exp_g;
    logic [9:0]       exp_b;
    logic             vs_fall;

    // Empty flag is used combinationally so a same-cycle refill is read at once;
    // reset gating keeps the FIFO untouched while the pipeline is held cleared.
    assign oFIFO_RD = iRST_N & iRequest & ~iFIFO_EMPTY;

    assign vs_fall = vs_d & ~iVGA_V_SYNC;

    // Expand the FIFO word (valid in stage 1) by bit replication so 0 and full scale map to the endpoints.
    always_comb begin
        exp_r = {iFIFO_DATA[15:11], iFIFO_DATA[15:11]};
        exp_g = {iFIFO_DATA[10:5], iFIFO_DATA[10:7]};
        exp_b = {iFIFO_DATA[4:0], iFIFO_DATA[4:0]};
        if (mode_q) begin
            exp_r = {iFIFO_DATA[7:0], iFIFO_DATA[7:6]};
            exp_g = {iFIFO_DATA[7:0], iFIFO_DATA[7:6]};
            exp_b = {iFIFO_DATA[7:0], iFIFO_DATA[7:6]};
        end
    end

    // Saturating running count including this cycle's underflow, if any.
    always_comb begin
        run_next = run_cnt;
        if (uf_d && (run_cnt != {CNT_W{1'b1}})) begin
            run_next = run_cnt + CNT_W'(1);
        end
    end

    // Stage 1: remember which cycles carried a request and which of those were starved.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            req_d <= 1'b0;
            uf_d  <= 1'b0;
        end else begin
            req_d <= iRequest;
            uf_d  <= iRequest & iFIFO_EMPTY;
        end
    end

    // Stage 2: registered pixel; fill colour wins over data, idle cycles drive black.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end else if (uf_d) begin
            red_q   <= FILL_R;
            green_q <= FILL_G;
            blue_q  <= FILL_B;
        end else if (req_d) begin
            red_q   <= exp_r;
            green_q <= exp_g;
            blue_q  <= exp_b;
        end else begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
        end
    end

    // Pixel format only changes at a frame boundary (V-sync falling edge) so a frame is never mixed.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            vs_d   <= 1'b0;
            mode_q <= 1'b0;
        end else begin
            vs_d <= iVGA_V_SYNC;
            if (vs_fall) begin
                mode_q <= iMODE;
            end
        end
    end

    // Per-frame underflow counting plus a sticky flag that only reset clears.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            run_cnt   <= '0;
            last_cnt  <= '0;
            sticky_uf <= 1'b0;
        end else begin
            sticky_uf <= sticky_uf | uf_d;
            if (vs_fall) begin
                last_cnt <= run_next;
                run_cnt  <= uf_d ? CNT_W'(1) : '0;
            end else begin
                run_cnt <= run_next;
            end
        end
    end

    assign oRed           = red_q;
    assign oGreen         = green_q;
    assign oBlue          = blue_q;
    assign oUnderflow     = sticky_uf;
    assign oUnderflow_Cnt = last_cnt;

endmodule

// File: tb/tb_vga_pixel_feeder.sv
// Directed bench for vga_pixel_feeder: main instance with 16-bit counters and a
// second instance with 4-bit counters sharing the same stimulus for saturation.
// Expected pixels are hand-expanded constants in the stimulus tables.
module tb_vga_pixel_feeder;

    logic        iCLK = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iRequest = 1'b0;
    logic        iVGA_V_SYNC = 1'b1;
    logic        iMODE = 1'b0;
    logic [15:0] iFIFO_DATA = 16'h0;
    logic        iFIFO_EMPTY = 1'b0;

    logic        oFIFO_RD;
    logic [9:0]  oRed, oGreen, oBlue;
    logic        oUnderflow;
    logic [15:0] oUnderflow_Cnt;

    logic        s_rd;
    logic [9:0]  s_red, s_green, s_blue;
    logic        s_uf;
    logic [3:0]  s_cnt;

    int checks = 0;
    int failures = 0;

    // Burst tables filled before each call of burst()
    logic [15:0] b_dat [0:23];
    logic        b_emp [0:23];
    logic [9:0]  b_er  [0:23];
    logic [9:0]  b_eg  [0:23];
    logic [9:0]  b_eb  [0:23];

    vga_pixel_feeder dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iRequest(iRequest), .iVGA_V_SYNC(iVGA_V_SYNC),
        .iMODE(iMODE), .iFIFO_DATA(iFIFO_DATA), .iFIFO_EMPTY(iFIFO_EMPTY),
        .oFIFO_RD(oFIFO_RD), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
        .oUnderflow(oUnderflow), .oUnderflow_Cnt(oUnderflow_Cnt)
    );

    vga_pixel_feeder #(.CNT_W(4)) dut_sat (
        .iCLK(iCLK), .iRST_N(iRST_N), .iRequest(iRequest), .iVGA_V_SYNC(iVGA_V_SYNC),
        .iMODE(iMODE), .iFIFO_DATA(iFIFO_DATA), .iFIFO_EMPTY(iFIFO_EMPTY),
        .oFIFO_RD(s_rd), .oRed(s_red), .oGreen(s_green), .oBlue(s_blue),
        .oUnderflow(s_uf), .oUnderflow_Cnt(s_cnt)
    );

    always #5 iCLK = ~iCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk_px(input string tag, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        chk({tag, ".R"}, 32'(oRed), 32'(r));
        chk({tag, ".G"}, 32'(oGreen), 32'(g));
        chk({tag, ".B"}, 32'(oBlue), 32'(b));
    endtask

    task automatic set_px(input int i, input logic [15:0] d, input logic e,
                          input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        b_dat[i] = d; b_emp[i] = e; b_er[i] = r; b_eg[i] = g; b_eb[i] = b;
    endtask

    // Back-to-back requests; FIFO word for request i is presented the cycle after it.
    task automatic burst(input int n, input string tag, output int rds);
        rds = 0;
        for (int i = 0; i < n + 3; i++) begin
            iRequest    = (i < n);
            iFIFO_EMPTY = (i < n) ? b_emp[i] : 1'b0;
            iFIFO_DATA  = (i >= 1 && i <= n) ? b_dat[i-1] : 16'h0;
            #1;
            if (oFIFO_RD) rds++;
            chk($sformatf("%s[%0d].rd", tag, i), 32'(oFIFO_RD), 32'((i < n) && !b_emp[i]));
            if (i >= 2 && i < n + 2)
                chk_px($sformatf("%s[%0d]", tag, i), b_er[i-2], b_eg[i-2], b_eb[i-2]);
            else
                chk_px($sformatf("%s[%0d]", tag, i), 10'h0, 10'h0, 10'h0);
            tick();
        end
        iRequest = 1'b0;
        iFIFO_DATA = 16'h0;
    endtask

    task automatic vsync_pulse();
        iVGA_V_SYNC = 1'b0;
        tick();
        tick();
        iVGA_V_SYNC = 1'b1;
        tick();
    endtask

    initial begin
        int rds;

        // Reset then idle
        repeat (5) tick();
        chk_px("in_reset", 10'h0, 10'h0, 10'h0);
        iRST_N = 1'b1;
        tick();
        tick();
        chk_px("idle", 10'h0, 10'h0, 10'h0);
        chk("idle.rd", 32'(oFIFO_RD), 32'd0);
        chk("idle.cnt", 32'(oUnderflow_Cnt), 32'd0);
        chk("idle.uf", 32'(oUnderflow), 32'd0);

        // RGB565 burst
        set_px(0, 16'hF800, 1'b0, 10'h3FF, 10'h000, 10'h000);
        set_px(1, 16'h07E0, 1'b0, 10'h000, 10'h3FF, 10'h000);
        set_px(2, 16'h001F, 1'b0, 10'h000, 10'h000, 10'h3FF);
        set_px(3, 16'hFFFF, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF);
        burst(4, "rgb", rds);
        chk("rgb.rds", 32'(rds), 32'd4);
        chk("rgb.uf", 32'(oUnderflow), 32'd0);

        // Underflow in the middle of three requests
        set_px(0, 16'h07E0, 1'b0, 10'h000, 10'h3FF, 10'h000);
        set_px(1, 16'hFFFF, 1'b1, 10'h3FF, 10'h000, 10'h000);
        set_px(2, 16'h001F, 1'b0, 10'h000, 10'h000, 10'h3FF);
        burst(3, "uf3", rds);
        chk("uf3.rds", 32'(rds), 32'd2);
        chk("uf3.uf", 32'(oUnderflow), 32'd1);
        chk("uf3.cnt_before_vs", 32'(oUnderflow_Cnt), 32'd0);

        // Four more starved requests: five in this frame
        for (int i = 0; i < 4; i++) set_px(i, 16'h1234, 1'b1, 10'h3FF, 10'h000, 10'h000);
        burst(4, "uf4", rds);
        chk("uf4.rds", 32'(rds), 32'd0);
        vsync_pulse();
        chk("frame5.cnt", 32'(oUnderflow_Cnt), 32'd5);

        // A clean frame reports zero, sticky flag remains
        set_px(0, 16'h07E0, 1'b0, 10'h000, 10'h3FF, 10'h000);
        burst(1, "clean", rds);
        vsync_pulse();
        chk("frame0.cnt", 32'(oUnderflow_Cnt), 32'd0);
        chk("frame0.uf", 32'(oUnderflow), 32'd1);

        // Mono mode selected mid-frame: no effect until the next V-sync edge
        iMODE = 1'b1;
        set_px(0, 16'h0080, 1'b0, 10'h000, 10'h041, 10'h000);
        burst(1, "mono_pre", rds);
        vsync_pulse();
        set_px(0, 16'h0080, 1'b0, 10'h202, 10'h202, 10'h202);
        set_px(1, 16'h00FF, 1'b0, 10'h3FF, 10'h3FF, 10'h3FF);
        set_px(2, 16'hFF00, 1'b0, 10'h000, 10'h000, 10'h000);
        burst(3, "mono", rds);
        vsync_pulse();

        // Twenty starved requests in one frame: 4-bit counter saturates
        for (int i = 0; i < 20; i++) set_px(i, 16'h00FF, 1'b1, 10'h3FF, 10'h000, 10'h000);
        burst(20, "sat", rds);
        vsync_pulse();
        chk("sat.cnt4", 32'(s_cnt), 32'd15);
        chk("sat.cnt16", 32'(oUnderflow_Cnt), 32'd20);

        // Async reset between clock edges in the middle of a burst
        iRequest = 1'b1;
        iFIFO_EMPTY = 1'b0;
        tick();
        iFIFO_DATA = 16'h00FF;
        tick();
        tick();
        chk_px("pre_rst", 10'h3FF, 10'h3FF, 10'h3FF);
        #2;
        iRST_N = 1'b0;
        #1;
        chk_px("async_rst", 10'h0, 10'h0, 10'h0);
        chk("async_rst.rd", 32'(oFIFO_RD), 32'd0);
        chk("async_rst.uf", 32'(oUnderflow), 32'd0);
        chk("async_rst.cnt", 32'(oUnderflow_Cnt), 32'd0);
        iRequest = 1'b0;
        iFIFO_DATA = 16'h0;
        tick();
        iRST_N = 1'b1;
        tick();
        tick();
        chk_px("post_rst", 10'h0, 10'h0, 10'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_pixel_feeder.md
Name: vga_pixel_feeder

Overview:
- Sits directly upstream of the VGA timing controller.
- Converts that controller's per-pixel request strobe into reads from the frame-buffer read FIFO, which is filled from SDRAM.
- Expands each FIFO word (RGB565 or 8-bit mono) to the controller's 10-bit R/G/B inputs, with a fixed latency that matches the controller's request lead.
- Substitutes a fill colour on FIFO underflow, and counts underflows per frame for debug readout.

Parameters:
- FILL_R, 10'h3FF, red channel emitted on underflow
- FILL_G, 10'h000, green channel emitted on underflow
- FILL_B, 10'h000, blue channel emitted on underflow
- CNT_W, 16, width of the underflow counters

Ports:
- iCLK  in  1  pixel clock, same clock as the VGA controller
- iRST_N  in  1  asynchronous active-low reset
- iRequest  in  1  pixel request from the VGA controller; high for each active pixel, 2 cycles ahead of data use
- iVGA_V_SYNC  in  1  VGA vertical sync, active low
- iMODE  in  1  pixel format: 0 = RGB565 in iFIFO_DATA[15:0]; 1 = mono8 in iFIFO_DATA[7:0]
- iFIFO_DATA  in  16  read FIFO data; normal (non-show-ahead) mode, valid the cycle after oFIFO_RD
- iFIFO_EMPTY  in  1  read FIFO empty flag
- oFIFO_RD  out  1  FIFO read strobe
- oRed  out  10  red pixel to the VGA controller
- oGreen  out  10  green pixel to the VGA controller
- oBlue  out  10  blue pixel to the VGA controller
- oUnderflow  out  1  sticky flag; set on any underflow, cleared only by reset
- oUnderflow_Cnt  out  CNT_W  underflow count of the last completed frame

Behaviour:
- Reset (async, iRST_N low): all outputs 0; pipeline valid/underflow bits 0; mode register 0; running counter 0. Reset mid-line discards in-flight pixels; no FIFO read is issued while reset is low.
- Read strobe: oFIFO_RD = iRequest & ~iFIFO_EMPTY (combinational). A read is never issued while the FIFO is empty.
- Pipeline stage 1 (cycle T+1 after request at T): registers req_d = iRequest and uf_d = iRequest & iFIFO_EMPTY. FIFO data is valid in this cycle.
- Pipeline stage 2 (cycle T+2): registered outputs.
  - If req_d & ~uf_d: expanded FIFO data.
  - If uf_d: FILL_R/G/B.
  - Otherwise: 0.
- Total latency from iRequest high to pixel on oRed/oGreen/oBlue is exactly 2 cycles. Back-to-back requests give one pixel per cycle with no bubbles.
- RGB565 expansion (mode 0), d = iFIFO_DATA:
  - R = {d[15:11], d[15:11]}
  - G = {d[10:5], d[10:7]}
  - B = {d[4:0], d[4:0]}
- Mono8 expansion (mode 1), y = d[7:0]: R = G = B = {y, y[7:6]}.
- Expansion endpoints: 0 maps to 10'h000; full scale maps to 10'h3FF.
- Mode latching: the registered mode is loaded from iMODE only on the falling edge of iVGA_V_SYNC (detected via a 1-cycle delayed copy). A mid-frame iMODE change therefore takes effect at the next frame.
- Underflow counting:
  - The running counter increments by 1 on each cycle with uf_d = 1, saturating at all-ones.
  - On a V-sync falling edge: oUnderflow_Cnt <= running value, including any increment in the same cycle. The running counter is then cleared to 0, or to 1 if uf_d is also high that cycle.
- oUnderflow is set on the first uf_d = 1 and stays set until reset.
- FIFO going empty mid-line: each starved request yields one fill pixel. When the FIFO refills, reading resumes. Starved pixels are not re-fetched, so the line shifts; this is intended as a visible fault indication.
- Simultaneous iRequest and iFIFO_EMPTY deassertion in the same cycle: the read is issued normally (the empty flag is sampled combinationally).

Test Plan:
- Reset then idle: iRST_N low 5 cycles, then high with iRequest = 0 → all outputs 0, oFIFO_RD = 0, oUnderflow_Cnt = 0.
- RGB565 burst: FIFO preloaded with 16'hF800, 16'h07E0, 16'h001F, 16'hFFFF; iRequest high 4 cycles from cycle T.
  - Expected on cycles T+2..T+5 as R/G/B: 3FF/000/000, 000/3FF/000, 000/000/3FF, 3FF/3FF/3FF.
  - oFIFO_RD high on T..T+3.
- Mono mode: iMODE = 1 set mid-frame, then a V-sync falling edge, then FIFO data 16'h0080 → no effect before the edge; after the edge, R = G = B = 10'h202.
- Underflow: 3 requests with the FIFO empty on the middle one → pixels are data, FILL (3FF/000/000), data; oFIFO_RD pulses 2 times; oUnderflow = 1.
- Per-frame count: 5 underflows in frame N, then a V-sync falling edge → oUnderflow_Cnt = 5, running counter 0. A frame with 0 underflows → oUnderflow_Cnt = 0 at its end, oUnderflow still 1.
- Saturation and async reset: CNT_W = 4 with 20 underflows in one frame → oUnderflow_Cnt = 15. Asserting iRST_N between clock edges mid-burst clears the outputs immediately.
